fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised successor to the single-register fetch stage. It decouples instruction memory from decode
//   with a DEPTH-entry in-order fetch queue. Instruction memory uses a pipelined req/gnt/rvalid interface and
//   may have several requests outstanding. On a writeback redirect it flushes the queue and discards stale
//   in-flight responses. Sits between imem and decode; the decode handshake is valid/ready.
// PARAMETERS
//   XLEN   32  address / PC width
//   ILEN   32  instruction width
//   DEPTH  4   queue entries (power of 2, >=2); bounds in-flight + buffered instructions
// PORTS
//   clk            in   1     clock
//   rst            in   1     synchronous active-high reset
//   rst_addr       in   XLEN  PC loaded while rst=1
//   imem_req_o     out  1     fetch request valid
//   imem_addr_o    out  XLEN  fetch address (current PC)
//   imem_gnt_i     in   1     request accepted this cycle (req&gnt)
//   imem_rvalid_i  in   1     response valid; responses return in grant order
//   imem_rdata_i   in   ILEN  response instruction
//   redir_i        in   1     jump taken (from writeback)
//   redir_addr_i   in   XLEN  jump target
//   fd_valid_o     out  1     instruction available to decode
//   fd_ready_i     in   1     decode accepts (pop on fd_valid_o&fd_ready_i)
//   fd_pc_o        out  XLEN  PC of head instruction
//   fd_instr_o     out  ILEN  head instruction
//   stall_o        out  1     high for the one cycle after a redirect
// BEHAVIOUR
//   Reset (rst=1 at edge): pc<=rst_addr. Pointers, count and drop_cnt go to 0; stall_o<=0. Outputs while rst=1:
//     imem_req_o=0, fd_valid_o=0.
//   Queue entry = {pc, instr, filled}. Three pointers: alloc (tail), fill, head. count = allocated entries,
//     width $clog2(DEPTH)+1.
//   Request: imem_req_o = !rst && !redir_i && count<DEPTH. imem_addr_o=pc. The address is held stable until gnt.
//   Grant (req&gnt): entry[alloc]<={pc,x,0}; alloc++; pc<=pc+4 (wraps mod 2^XLEN).
//   Response (rvalid and drop_cnt==0): entry[fill].instr<=rdata, filled<=1; fill++.
//   Response with drop_cnt>0: discard the data; drop_cnt--.
//   Output: fd_valid_o = count>0 && entry[head].filled && !redir_i (combinational from state).
//     fd_pc_o/fd_instr_o come from entry[head].
//   Pop (fd_valid_o&fd_ready_i): head++, count--. Grant, fill and pop may all occur in the same cycle;
//     count += gnt - pop.
//   Minimum latency: gnt at cycle G, rvalid at R>=G+1 -> fd_valid_o at R+1.
//   Redirect (redir_i=1): highest priority. pc<=redir_addr_i; alloc/fill/head/count<=0.
//     drop_cnt <= drop_cnt + (alloc-fill entries outstanding) - (rvalid this cycle).
//     A response in the redirect cycle is consumed as stale. No request is issued and no pop occurs in the
//     redirect cycle. stall_o<=1 for the next cycle, otherwise 0.
//   Back-to-back redirects: the last target wins and drop_cnt accumulates. drop_cnt never exceeds DEPTH.
//   Request withdrawal (req dropped before gnt because of a redirect) is legal on this imem protocol.
//   rvalid with no outstanding and drop_cnt==0 is a protocol error: ignored in RTL, flagged by a sim assertion.
//   Queue full (count==DEPTH): imem_req_o=0 until a pop.
//   Empty/unfilled head: fd_valid_o=0.
//   Reset mid-operation: all state is cleared on the edge regardless of pending rvalid. Responses arriving
//     after reset are the environment's responsibility (bench idles imem during reset).
// TESTING
//   1. Reset with rst_addr=0x1000, fd_ready=1, gnt=1, rvalid 1 cycle after gnt -> addrs 0x1000,0x1004,...;
//      fd_pc sequence 0x1000,0x1004,... with no gaps after fill.
//   2. fd_ready=0, gnt=1, rvalid always -> exactly DEPTH(4) grants, then imem_req_o=0. Release ready ->
//      4 pops in order, requests resume.
//   3. Two grants outstanding (0x1000,0x1004), redir_i=1 to 0x2000 -> next req addr 0x2000, stall_o=1 for one
//      cycle, the two late responses are dropped, first fd_pc_o=0x2000.
//   4. Redirect in the same cycle as rvalid with 1 outstanding -> drop_cnt stays 0. The next response is
//      accepted as the 0x2000 instruction.
//   5. Random gnt/rvalid delays with random fd_ready over 10k cycles -> scoreboard shows fd_pc/instr match
//      in-order memory model, with no loss or duplication.
//   6. rst asserted while the queue is full and 2 requests are outstanding -> next cycle fd_valid_o=0,
//      imem_req_o=0; after release the first addr is rst_addr.

Source files
------------

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue between a pipelined req/gnt/rvalid instruction memory and decode.
// Flushes on redirect and silently drops the responses that were still in flight at that moment.
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rst_addr,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            redir_i,
    input  logic [XLEN-1:0] redir_addr_i,
    output logic            fd_valid_o,
    input  logic            fd_ready_i,
    output logic [XLEN-1:0] fd_pc_o,
    output logic [ILEN-1:0] fd_instr_o,
    output logic            stall_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [AW-1:0]   alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [CW-1:0]   count_q, count_d, out_q, out_d, drop_cnt_q, drop_cnt_d;
    logic            stall_q, stall_d;
    logic [XLEN-1:0] ent_pc_q    [DEPTH];
    logic [XLEN-1:0] ent_pc_d    [DEPTH];
    logic [ILEN-1:0] ent_instr_q [DEPTH];
    logic [ILEN-1:0] ent_instr_d [DEPTH];
    logic [DEPTH-1:0] ent_filled_q, ent_filled_d;

    logic            grant, pop, accept, drop, stale_rsp;
    logic [CW:0]     inflight;

    // Stale responses still owed by memory consume queue budget, which keeps drop_cnt within DEPTH.
    assign inflight    = {1'b0, count_q} + {1'b0, drop_cnt_q};
    assign imem_req_o  = !rst && !redir_i && (inflight < DEPTH_W);
    assign imem_addr_o = pc_q;
    assign fd_valid_o  = !rst && !redir_i && (count_q != '0) && ent_filled_q[head_q];
    assign fd_pc_o     = ent_pc_q[head_q];
    assign fd_instr_o  = ent_instr_q[head_q];
    assign stall_o     = stall_q;

    assign grant     = imem_req_o && imem_gnt_i;
    assign pop       = fd_valid_o && fd_ready_i;
    assign drop      = imem_rvalid_i && (drop_cnt_q != '0);
    assign accept    = imem_rvalid_i && (drop_cnt_q == '0) && (out_q != '0);
    assign stale_rsp = imem_rvalid_i && ((drop_cnt_q != '0) || (out_q != '0));

    always_comb begin
        pc_d         = pc_q;
        alloc_d      = alloc_q;
        fill_d       = fill_q;
        head_d       = head_q;
        count_d      = count_q;
        out_d        = out_q;
        drop_cnt_d   = drop_cnt_q;
        stall_d      = redir_i;
        ent_pc_d     = ent_pc_q;
        ent_instr_d  = ent_instr_q;
        ent_filled_d = ent_filled_q;

        if (redir_i) begin
            pc_d       = redir_addr_i;
            alloc_d    = '0;
            fill_d     = '0;
            head_d     = '0;
            count_d    = '0;
            out_d      = '0;
            drop_cnt_d = drop_cnt_q + out_q - CW'(stale_rsp);
        end else begin
            if (grant) begin
                ent_pc_d[alloc_q]     = pc_q;
                ent_filled_d[alloc_q] = 1'b0;
                alloc_d               = alloc_q + AW'(1);
                pc_d                  = pc_q + XLEN'(4);
            end
            if (accept) begin
                ent_instr_d[fill_q]  = imem_rdata_i;
                ent_filled_d[fill_q] = 1'b1;
                fill_d               = fill_q + AW'(1);
            end
            if (drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(grant) - CW'(pop);
            out_d   = out_q + CW'(grant) - CW'(accept);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= rst_addr;
            alloc_q      <= '0;
            fill_q       <= '0;
            head_q       <= '0;
            count_q      <= '0;
            out_q        <= '0;
            drop_cnt_q   <= '0;
            stall_q      <= 1'b0;
            ent_filled_q <= '0;
        end else begin
            pc_q         <= pc_d;
            alloc_q      <= alloc_d;
            fill_q       <= fill_d;
            head_q       <= head_d;
            count_q      <= count_d;
            out_q        <= out_d;
            drop_cnt_q   <= drop_cnt_d;
            stall_q      <= stall_d;
            ent_filled_q <= ent_filled_d;
        end
        ent_pc_q    <= ent_pc_d;
        ent_instr_q <= ent_instr_d;
    end

    // A response with nothing owed is a memory-side protocol error; the RTL ignores it.
    assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid_i && (drop_cnt_q == '0) && (out_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomised checks of fetch_queue against an in-order memory model and a PC scoreboard.
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] rst_addr;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;
    logic            redir_i;
    logic [XLEN-1:0] redir_addr_i;
    logic            fd_valid_o;
    logic            fd_ready_i;
    logic [XLEN-1:0] fd_pc_o;
    logic [ILEN-1:0] fd_instr_o;
    logic            stall_o;

    fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rst_addr     (rst_addr),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redir_i      (redir_i),
        .redir_addr_i (redir_addr_i),
        .fd_valid_o   (fd_valid_o),
        .fd_ready_i   (fd_ready_i),
        .fd_pc_o      (fd_pc_o),
        .fd_instr_o   (fd_instr_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          gnt_pct = 100;
    int          rsp_min = 1;
    int          rsp_max = 1;
    bit          ready_rand = 1'b0;
    logic        ready_val = 1'b1;
    bit          saw_gnt, saw_pop;
    logic [31:0] gnt_addr, pop_pc, pop_instr;
    int          n_gnt, n_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h3C5A_A5C3;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, well away from the rising edge.
    task automatic cycle(input logic r_rst, input logic r_redir, input logic [31:0] r_target);
        pend_t p;
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        rst          = r_rst;
        redir_i      = r_redir;
        redir_addr_i = r_target;
        fd_ready_i   = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        if (r_rst) begin
            imem_gnt_i = 1'b0;
            pend.delete();
        end else begin
            imem_gnt_i = ($urandom_range(1, 100) <= gnt_pct);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(pend[0].addr);
            end
        end
        #1;
        saw_gnt = 1'b0;
        saw_pop = 1'b0;
        if (r_rst) begin
            exp_q.delete();
            model_pc = rst_addr;
        end else begin
            if (imem_rvalid_i) void'(pend.pop_front());
            if (imem_req_o && imem_gnt_i) begin
                saw_gnt  = 1'b1;
                gnt_addr = imem_addr_o;
                n_gnt++;
                check("gnt_addr", imem_addr_o, model_pc);
                p.addr = imem_addr_o;
                p.due  = cyc + $urandom_range(rsp_min, rsp_max);
                pend.push_back(p);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            if (fd_valid_o && fd_ready_i) begin
                saw_pop   = 1'b1;
                pop_pc    = fd_pc_o;
                pop_instr = fd_instr_o;
                n_pop++;
                check("pop_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("fd_pc", fd_pc_o, e);
                    check("fd_instr", fd_instr_o, mem_word(e));
                end
            end
            if (r_redir) begin
                exp_q.delete();
                model_pc = r_target;
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check("rst_req", imem_req_o, 0);
            check("rst_valid", fd_valid_o, 0);
        end
    endtask

    initial begin
        logic [31:0] first_pc;
        logic [31:0] tgt;
        int          cnt;
        rst = 1'b1; rst_addr = 32'h1000; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        imem_rdata_i = '0; redir_i = 1'b0; redir_addr_i = '0; fd_ready_i = 1'b0;

        // Streaming: no gaps once the first instruction lands.
        gnt_pct = 100; rsp_min = 1; rsp_max = 1; ready_val = 1'b1;
        do_reset(2);
        check("t1_stall_rst", stall_o, 0);
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("t1_valid", fd_valid_o, (k >= 3) ? 1 : 0);
            if (k == 1) check("t1_first_addr", gnt_addr, 32'h1000);
            if (k == 3) check("t1_first_pc", pop_pc, 32'h1000);
        end

        // Decode stalled: exactly DEPTH grants, then in-order drain and resume.
        ready_val = 1'b0;
        do_reset(1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (saw_gnt) cnt++;
        end
        check("t2_grants", cnt, DEPTH);
        check("t2_req_full", imem_req_o, 0);
        check("t2_head_valid", fd_valid_o, 1);
        check("t2_head_pc", fd_pc_o, 32'h1000);
        ready_val = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("t2_pop", saw_pop, 1);
            check("t2_pop_pc", pop_pc, 32'h1000 + 32'(4 * k));
            check("t2_gnt", saw_gnt, (k == 0) ? 0 : 1);
            if (k == 1) check("t2_resume_addr", gnt_addr, 32'h1010);
        end

        // Redirect with two requests in flight.
        rsp_min = 5; rsp_max = 5;
        do_reset(1);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_two_out", n_gnt >= 2, 1);
        gnt_pct = 0;
        cycle(1'b0, 1'b1, 32'h2000);
        check("t3_redir_req", imem_req_o, 0);
        check("t3_redir_valid", fd_valid_o, 0);
        check("t3_redir_stall", stall_o, 0);
        gnt_pct = 100;
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_stall", stall_o, 1);
        check("t3_req", imem_req_o, 1);
        check("t3_addr", imem_addr_o, 32'h2000);
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_stall_clr", stall_o, 0);
        first_pc = 32'h0;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (saw_pop) begin
                first_pc = pop_pc;
                break;
            end
        end
        check("t3_first_pc", first_pc, 32'h2000);

        // Redirect coinciding with the only outstanding response.
        rsp_min = 1; rsp_max = 1;
        do_reset(1);
        cycle(1'b0, 1'b0, 32'h0);
        check("t4_grant", saw_gnt, 1);
        gnt_pct = 0;
        cycle(1'b0, 1'b1, 32'h2000);
        check("t4_rvalid_in_redir", imem_rvalid_i, 1);
        gnt_pct = 100;
        cycle(1'b0, 1'b0, 32'h0);
        check("t4_stall", stall_o, 1);
        check("t4_addr", gnt_addr, 32'h2000);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t4_pop", saw_pop, 1);
        check("t4_pc", pop_pc, 32'h2000);
        check("t4_instr", pop_instr, mem_word(32'h2000));

        // Reset while full with two responses still owed.
        ready_val = 1'b0; rsp_min = 3; rsp_max = 3;
        do_reset(1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 32'h0);
        check("t6_full_req", imem_req_o, 0);
        check("t6_full_valid", fd_valid_o, 1);
        check("t6_owed", pend.size(), 2);
        do_reset(2);
        ready_val = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        check("t6_req", imem_req_o, 1);
        check("t6_addr", imem_addr_o, 32'h1000);

        // Random grant/response timing, decode back-pressure and redirects.
        gnt_pct = 60; rsp_min = 1; rsp_max = 4; ready_rand = 1'b1;
        do_reset(1);
        n_pop = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                tgt = $urandom;
                tgt[1:0] = 2'b00;
                cycle(1'b0, 1'b1, tgt);
            end else begin
                cycle(1'b0, 1'b0, 32'h0);
            end
        end
        check("t5_pops", n_pop > 1000, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
